rx_nibble_fifo: RTL and testbench

Receive-side buffer that sits directly downstream of the receiver unit. It captures each decoded 4-bit word together with its correction status into a first-word-fall-through FIFO, and drives back-pressure into the receiver's `not_ready_in`. It also keeps saturating counts of corrected and uncorrectable words for display logic and the bench.

---
 rtl/rx_nibble_fifo.sv | 151 +++++++++++++++
 tb/tb_rx_nibble_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_nibble_fifo.sv
// rx_nibble_fifo
//   Receive-side first-word-fall-through FIFO for decoded 4-bit words plus
//   their error status.
//   - Drives registered back-pressure to the upstream receiver.
//   - Keeps saturating counts of corrected and uncorrectable words.
//
// Optional feature macro: RX_DROP_UNCORR_EN
//   When defined, uncorrectable words are counted but not stored, and out_err
//   is tied to 0.
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   in_data        decoded word from the receiver
//   in_valid       one-cycle strobe qualifying in_data and the error flags
//   in_err_corr    the word was single-bit corrected
//   in_err_unc     the word is uncorrectable
//   not_ready_out  registered back-pressure to the receiver
//   out_data       head entry data (combinational read)
//   out_err        head entry was stored with in_err_unc set
//   out_valid      FIFO non-empty
//   out_ready      consumer pops the head while out_valid is high
//   count          current occupancy
//   corr_cnt       saturating count of corrected words
//   unc_cnt        saturating count of uncorrectable words
//   overflow       sticky flag: a write was lost
//   clr_stats      synchronous clear of corr_cnt, unc_cnt and overflow
module rx_nibble_fifo #(
  parameter int DEPTH        = 8,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [3:0]                   in_data,
  input  logic                         in_valid,
  input  logic                         in_err_corr,
  input  logic                         in_err_unc,
  output logic                         not_ready_out,
  output logic [3:0]                   out_data,
  output logic                         out_err,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [7:0]                   corr_cnt,
  output logic [7:0]                   unc_cnt,
  output logic                         overflow,
  input  logic                         clr_stats
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - AFULL_MARGIN);

  // Storage: {err, data}. Not reset; contents behind rd_ptr are don't-care.
  logic [4:0]    mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    corr_q, corr_d;
  logic [7:0]    unc_q, unc_d;
  logic          ovf_q, ovf_d;
  logic          nrdy_q, nrdy_d;

  logic          eligible;
  logic          push;
  logic          pop;

`ifdef RX_DROP_UNCORR_EN
  assign eligible = ~in_err_unc;
`else
  assign eligible = 1'b1;
`endif

  assign pop  = (count_q != '0) && out_ready;
  // A pop in the same cycle frees the slot, so a push at full is accepted.
  assign push = in_valid && eligible && ((count_q < FULL_LVL) || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    corr_d   = corr_q;
    unc_d    = unc_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    // A stored-eligible word arriving at full with no pop is lost.
    if (in_valid && eligible && (count_q == FULL_LVL) && !pop) ovf_d = 1'b1;

    // Counters run on every valid word, stored or not.
    if (in_valid && in_err_corr && !in_err_unc && (corr_q != 8'hFF))
      corr_d = corr_q + 8'd1;
    if (in_valid && in_err_unc && (unc_q != 8'hFF))
      unc_d = unc_q + 8'd1;

    // Clear wins over any same-cycle increment or overflow set.
    if (clr_stats) begin
      corr_d = '0;
      unc_d  = '0;
      ovf_d  = 1'b0;
    end

    // Back-pressure is computed from the next occupancy so it lands on the
    // same edge that crosses the threshold.
    nrdy_d = (count_d >= AFULL_LVL);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      corr_q   <= '0;
      unc_q    <= '0;
      ovf_q    <= 1'b0;
      nrdy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      corr_q   <= corr_d;
      unc_q    <= unc_d;
      ovf_q    <= ovf_d;
      nrdy_q   <= nrdy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_err_unc, in_data};
  end

  assign out_data      = mem_q[rd_ptr_q][3:0];
`ifdef RX_DROP_UNCORR_EN
  assign out_err       = 1'b0;
`else
  assign out_err       = mem_q[rd_ptr_q][4];
`endif
  assign out_valid     = (count_q != '0);
  assign count         = count_q;
  assign corr_cnt      = corr_q;
  assign unc_cnt       = unc_q;
  assign overflow      = ovf_q;
  assign not_ready_out = nrdy_q;

endmodule

// File: tb/tb_rx_nibble_fifo.sv
module tb_rx_nibble_fifo;

  logic       clk;
  logic       rstn;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_err_corr;
  logic       in_err_unc;
  logic       not_ready_out;
  logic [3:0] out_data;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] count;
  logic [7:0] corr_cnt;
  logic [7:0] unc_cnt;
  logic       overflow;
  logic       clr_stats;

  int errors = 0;
  int checks = 0;

  rx_nibble_fifo #(.DEPTH(8), .AFULL_MARGIN(2)) dut (
    .clk(clk), .rstn(rstn),
    .in_data(in_data), .in_valid(in_valid),
    .in_err_corr(in_err_corr), .in_err_unc(in_err_unc),
    .not_ready_out(not_ready_out),
    .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .count(count),
    .corr_cnt(corr_cnt), .unc_cnt(unc_cnt),
    .overflow(overflow), .clr_stats(clr_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; leaves the bench 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  logic [3:0] drain_exp [8];

  initial begin
    rstn = 1'b0; in_data = '0; in_valid = 0; in_err_corr = 0; in_err_unc = 0;
    out_ready = 0; clr_stats = 0;

    // Reset state
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_not_ready", 32'(not_ready_out), 0);
    chk("rst_corr", 32'(corr_cnt), 0);
    chk("rst_unc", 32'(unc_cnt), 0);
    chk("rst_overflow", 32'(overflow), 0);
    #1 rstn = 1'b1;
    tick();

    // Three pushes, then stream them out
    push(4'h3); push(4'hA); push(4'h5);
    chk("p3_count", 32'(count), 3);
    chk("p3_head", 32'(out_data), 32'h3);
    chk("p3_valid", 32'(out_valid), 1);
    chk("p3_nrdy", 32'(not_ready_out), 0);
    out_ready = 1'b1;
    tick(); chk("pop1_head", 32'(out_data), 32'hA);
    tick(); chk("pop2_head", 32'(out_data), 32'h5);
    tick(); chk("pop3_valid", 32'(out_valid), 0);
    chk("pop3_count", 32'(count), 0);
    out_ready = 1'b0;
    $display("t=%0t three-word stream done", $time);

    // Back-pressure threshold (DEPTH-AFULL_MARGIN = 6)
    push(4'h1); push(4'h2); push(4'h3); push(4'h4); push(4'h5);
    chk("af5_nrdy", 32'(not_ready_out), 0);
    push(4'h6);
    chk("af6_nrdy", 32'(not_ready_out), 1);
    chk("af6_count", 32'(count), 6);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("af_pop_nrdy", 32'(not_ready_out), 0);
    chk("af_pop_count", 32'(count), 5);
    chk("af_pop_head", 32'(out_data), 32'h2);

    // Fill to full, then overflow, then push with simultaneous pop at full
    push(4'h7); push(4'h8); push(4'h9);
    chk("full_count", 32'(count), 8);
    chk("full_nrdy", 32'(not_ready_out), 1);
    chk("full_ovf_pre", 32'(overflow), 0);
    push(4'hF);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 8);
    chk("ovf_head", 32'(out_data), 32'h2);
    out_ready = 1'b1;
    push(4'hE);
    chk("pushpop_count", 32'(count), 8);
    chk("pushpop_head", 32'(out_data), 32'h3);
    drain_exp = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hE};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), 32'(out_data), 32'(drain_exp[i]));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_count", 32'(count), 0);
    chk("drain_nrdy", 32'(not_ready_out), 0);
    $display("t=%0t full/overflow sequence done", $time);

    // Corrected-word counter saturation
    in_err_corr = 1'b1;
    in_valid    = 1'b1;
    for (int i = 0; i < 254; i++) begin
      in_data = 4'(i);
      tick();
    end
    chk("corr_254", 32'(corr_cnt), 254);
    tick();
    chk("corr_255", 32'(corr_cnt), 255);
    for (int i = 255; i < 300; i++) begin
      in_data = 4'(i);
      tick();
    end
    chk("corr_sat", 32'(corr_cnt), 255);
    chk("corr_unc", 32'(unc_cnt), 0);
    chk("corr_count", 32'(count), 8);
    chk("corr_ovf", 32'(overflow), 1);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0; in_valid = 1'b0; in_err_corr = 1'b0;
    chk("clr_corr", 32'(corr_cnt), 0);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_count", 32'(count), 8);
    chk("clr_head", 32'(out_data), 32'h0);
    out_ready = 1'b1;
    repeat (8) tick();
    out_ready = 1'b0;
    chk("drain2_count", 32'(count), 0);
    $display("t=%0t counter saturation done", $time);

    // Uncorrectable word (corr flag also set: must not count as corrected)
    in_err_unc = 1'b1; in_err_corr = 1'b1;
    push(4'h7);
    in_err_unc = 1'b0; in_err_corr = 1'b0;
    chk("unc_cnt", 32'(unc_cnt), 1);
    chk("unc_corr", 32'(corr_cnt), 0);
    chk("unc_ovf", 32'(overflow), 0);
`ifdef RX_DROP_UNCORR_EN
    chk("unc_count", 32'(count), 0);
    chk("unc_valid", 32'(out_valid), 0);
`else
    chk("unc_count", 32'(count), 1);
    chk("unc_out_err", 32'(out_err), 1);
    chk("unc_out_data", 32'(out_data), 32'h7);
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("unc_drain", 32'(count), 0);
    $display("t=%0t uncorrectable word done", $time);

    // Asynchronous reset mid-stream (6 entries so back-pressure is active)
    push(4'h1); push(4'h2); push(4'h3); push(4'h4); push(4'h5); push(4'h6);
    chk("pre_rst_count", 32'(count), 6);
    chk("pre_rst_nrdy", 32'(not_ready_out), 1);
    #3 rstn = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_nrdy", 32'(not_ready_out), 0);
    chk("arst_unc", 32'(unc_cnt), 0);
    #2 rstn = 1'b1;
    push(4'hC);
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_count", 32'(count), 1);
    chk("post_rst_data", 32'(out_data), 32'hC);
    chk("post_rst_err", 32'(out_err), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_rst_pop", 32'(out_valid), 0);
    $display("t=%0t async reset sequence done", $time);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
